// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response bundle between execute-stage control and the mul/div unit
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, 32 cycles per op, 1-cycle divide special cases
module muldiv_unit (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, next_state;
  logic        busy_d, done_d, busy_q, done_q;

  logic [2:0]  op_q;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] opnd_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [4:0]  cnt_q;
  logic [31:0] result_q;

  logic        accept;
  logic        in_div;
  logic        signed_a, signed_b;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b;
  logic        div_zero, div_ovf, fast;
  logic [31:0] fast_result;

  logic        run_div;
  logic        last_iter;
  logic [32:0] mul_sum;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        fits;
  logic [31:0] iter_hi, iter_lo;
  logic [63:0] prod, prod_s;
  logic [31:0] quot, remd;
  logic [31:0] run_result;

  // ---------------- acceptance decode ----------------
  assign accept = bus.start && (state != RUN);
  assign in_div = bus.op[2];

  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (bus.op)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      3'b010:  signed_a = 1'b1;
      default: ;
    endcase
  end

  assign neg_a = signed_a && bus.a[31];
  assign neg_b = signed_b && bus.b[31];
  assign mag_a = neg_a ? (~bus.a + 32'd1) : bus.a;
  assign mag_b = neg_b ? (~bus.b + 32'd1) : bus.b;

  assign div_zero = in_div && (bus.b == 32'd0);
  assign div_ovf  = in_div && !bus.op[0] && (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
  assign fast     = div_zero || div_ovf;

  // op[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    fast_result = 32'd0;
    if (div_zero)
      fast_result = bus.op[1] ? bus.a : 32'hFFFF_FFFF;
    else if (div_ovf)
      fast_result = bus.op[1] ? 32'd0 : 32'h8000_0000;
  end

  // ---------------- iteration datapath ----------------
  // hi/lo hold {product high, multiplier} for multiplies and {remainder, dividend/quotient} for divides
  assign run_div   = op_q[2];
  assign last_iter = (cnt_q == 5'd31);

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign shifted = {hi_q, lo_q[31]};
  assign trial   = shifted - {1'b0, opnd_q};
  assign fits    = !trial[32];

  assign iter_hi = run_div ? (fits ? trial[31:0] : shifted[31:0]) : mul_sum[32:1];
  assign iter_lo = run_div ? {lo_q[30:0], fits} : {mul_sum[0], lo_q[31:1]};

  assign prod   = {iter_hi, iter_lo};
  assign prod_s = neg_q ? (~prod + 64'd1) : prod;
  assign quot   = neg_q ? (~iter_lo + 32'd1) : iter_lo;
  assign remd   = neg_r ? (~iter_hi + 32'd1) : iter_hi;

  always_comb begin
    run_result = 32'd0;
    case (op_q)
      3'b000:                 run_result = prod_s[31:0];
      3'b001, 3'b010, 3'b011: run_result = prod_s[63:32];
      3'b100, 3'b101:         run_result = quot;
      default:                run_result = remd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 3'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      opnd_q   <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
    end else if (accept) begin
      op_q   <= bus.op;
      neg_q  <= neg_a ^ neg_b;
      neg_r  <= neg_a;
      opnd_q <= in_div ? mag_b : mag_a;
      hi_q   <= 32'd0;
      lo_q   <= in_div ? mag_a : mag_b;
      cnt_q  <= 5'd0;
      if (fast)
        result_q <= fast_result;
    end else if (state == RUN) begin
      hi_q  <= iter_hi;
      lo_q  <= iter_lo;
      cnt_q <= cnt_q + 5'd1;
      if (last_iter)
        result_q <= run_result;
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (bus.start)
          next_state = fast ? DONE : RUN;
        else
          next_state = IDLE;
      end
      RUN:     next_state = last_iter ? DONE : RUN;
      default: next_state = IDLE;
    endcase
  end

  // flags are decoded from the next state so the outputs themselves come straight from flops
  always_comb begin
    busy_d = (next_state == RUN);
    done_d = (next_state == DONE);
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
